ac_zone_scheduler: RTL and testbench
====================================

AC_ZONE_SCHEDULER -- requirements
Module: ac_zone_scheduler

Interface
REQ-001 Parameters SHALL be: MAX_DWELL, 16, maximum SERVE cycles per grant (2..255); LOCKOUT, 4, plant-off cycles between grants (1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 temperature  input  20  four packed unsigned 5-bit zone temperatures; zone n = bits [5n+4:5n].
REQ-005 zone_en  input  4  per-zone enable; disabled zones raise no demand.
REQ-006 heating  output  1  shared plant heating command, registered.
REQ-007 cooling  output  1  shared plant cooling command, registered.
REQ-008 valve  output  4  one-hot valve to the served zone, registered; all zero when not serving.
REQ-009 zone_sel  output  2  index of the last granted zone, registered.
REQ-010 busy  output  1  high in SERVE and LOCKOUT, registered.

Function
REQ-011 Heat demand for zone n SHALL be zone_en[n] and temp < 18; cool demand SHALL be zone_en[n] and temp > 22; 18..22 means no demand.
REQ-012 The FSM SHALL have the states IDLE, SERVE and LOCKOUT.
REQ-013 In IDLE, if any zone has demand, the block SHALL grant the first demanding zone scanning from rr_ptr upward modulo 4 and enter SERVE on the next edge.
REQ-014 The mode SHALL be latched at grant (heat if heat demand, otherwise cool); heating/cooling and valve SHALL assert in the first SERVE cycle, one cycle after demand is sampled in IDLE.
REQ-015 heating and cooling SHALL never be high together, and SHALL be low outside SERVE.
REQ-016 SERVE SHALL end on the next edge when the served zone is satisfied (heat: temp >= 20; cool: temp <= 20), when its zone_en drops, or after MAX_DWELL SERVE cycles, whichever occurs first.
REQ-017 On leaving SERVE, the block SHALL enter LOCKOUT with all plant outputs low, and rr_ptr SHALL become granted zone + 1 modulo 4 (wrap 3 -> 0).
REQ-018 LOCKOUT SHALL last exactly LOCKOUT cycles and then return to IDLE, regardless of demand.
REQ-019 Demand changes in other zones during SERVE or LOCKOUT SHALL be ignored until IDLE.
REQ-020 A mode change (heat to cool or cool to heat) between consecutive grants SHALL always pass through LOCKOUT.
REQ-021 The dwell and lockout counters SHALL saturate and never wrap.

Reset
REQ-022 While rst is high at an edge: state = IDLE, heating = 0, cooling = 0, valve = 0, zone_sel = 0, busy = 0, rr_ptr = 0, counters = 0.
REQ-023 Reset asserted mid-SERVE or mid-LOCKOUT SHALL abort immediately with no lockout; arbitration resumes from zone 0 on the first edge after rst falls.

Configuration
REQ-024 With macro AC_SCHED_ZONE0_PRIORITY_EN defined, zone 0 SHALL win every IDLE arbitration when it has demand, and the other zones use round-robin among themselves.
REQ-025 Without AC_SCHED_ZONE0_PRIORITY_EN, arbitration SHALL be pure round-robin per REQ-013.

Verification
REQ-026 Reset, then all zones at 20 -> heating = cooling = 0, valve = 0000, busy = 0 indefinitely.
REQ-027 Zone 2 = 15, others at 20, all enabled -> one cycle later heating = 1, valve = 0100, zone_sel = 2; raise zone 2 to 20 -> next edge LOCKOUT, outputs 0 for 4 cycles, then IDLE.
REQ-028 Zones 0 and 1 both at 25, never satisfied -> zone 0 cooled for 16 cycles, 4 lockout cycles, then zone 1 for 16 cycles, alternating thereafter; heating never asserts.
REQ-029 Zone 3 = 10 served, then dwell expires with zone 0 = 10 -> rr_ptr wraps to 0 and zone 0 is granted next.
REQ-030 Zone 1 in SERVE, zone_en[1] dropped -> LOCKOUT next edge; rst raised mid-LOCKOUT -> all outputs 0 next edge and IDLE with rr_ptr = 0.
REQ-031 With AC_SCHED_ZONE0_PRIORITY_EN, zones 0 and 3 continuously at 10 -> zone 0 granted every time; without the macro -> zones 0 and 3 alternate.

Source files
------------

// File: rtl/ac_zone_scheduler.sv
// ac_zone_scheduler: shares one heating/cooling plant between four zones.
// Idle demand is arbitrated round-robin. A granted zone is served until it
// is satisfied, is disabled, or its dwell limit expires. A fixed lockout
// with the plant off always follows a grant.
// Optional feature macro: AC_SCHED_ZONE0_PRIORITY_EN. When it is defined,
// zone 0 wins every idle arbitration in which it has demand.
module ac_zone_scheduler #(
  parameter int MAX_DWELL = 16,
  parameter int LOCKOUT   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] temperature,
  input  logic [3:0]  zone_en,
  output logic        heating,
  output logic        cooling,
  output logic [3:0]  valve,
  output logic [1:0]  zone_sel,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SERVE   = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  localparam logic [4:0] HEAT_BELOW = 5'd18;
  localparam logic [4:0] COOL_ABOVE = 5'd22;
  localparam logic [4:0] SETPOINT   = 5'd20;
  localparam logic [7:0] DWELL_MAX  = 8'(MAX_DWELL);
  localparam logic [7:0] LOCK_MAX   = 8'(LOCKOUT);
  localparam logic [7:0] CNT_SAT    = 8'hFF;

  state_t      state;
  logic        mode_heat;
  logic [1:0]  rr_ptr;
  logic [7:0]  dwell_cnt;
  logic [7:0]  lock_cnt;

  logic [3:0]  heat_dem;
  logic [3:0]  cool_dem;
  logic [3:0]  any_dem;
  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [4:0]  served_temp;
  logic        satisfied;
  logic        serve_done;

  // Per-zone demand: below 18 wants heat, above 22 wants cool, and a disabled zone wants nothing.
  always_comb begin
    heat_dem = 4'b0000;
    cool_dem = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      heat_dem[n] = zone_en[n] && (temperature[5*n +: 5] < HEAT_BELOW);
      cool_dem[n] = zone_en[n] && (temperature[5*n +: 5] > COOL_ABOVE);
    end
    any_dem = heat_dem | cool_dem;
  end

`ifdef AC_SCHED_ZONE0_PRIORITY_EN
  // Zone 0 wins whenever it has demand. Otherwise the first demanding zone among 1..3 is taken, scanning upward from rr_ptr.
  always_comb begin
    logic [1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (any_dem[cand] && (cand != 2'd0)) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (any_dem[0]) begin
      grant_valid = 1'b1;
      grant_idx   = 2'd0;
    end
  end
`else
  // Pure round-robin: take the first demanding zone scanning upward from rr_ptr. The reverse loop lets the smallest offset win.
  always_comb begin
    logic [1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (any_dem[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end
`endif

  // Work out when the zone currently being served should release the plant.
  always_comb begin
    served_temp = 5'd0;
    case (zone_sel)
      2'd0:    served_temp = temperature[4:0];
      2'd1:    served_temp = temperature[9:5];
      2'd2:    served_temp = temperature[14:10];
      default: served_temp = temperature[19:15];
    endcase
    satisfied  = mode_heat ? (served_temp >= SETPOINT) : (served_temp <= SETPOINT);
    serve_done = satisfied || !zone_en[zone_sel] || (dwell_cnt >= DWELL_MAX);
  end

  // Scheduler state machine. All plant outputs are registered and are updated together with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mode_heat <= 1'b0;
      rr_ptr    <= 2'd0;
      dwell_cnt <= 8'd0;
      lock_cnt  <= 8'd0;
      heating   <= 1'b0;
      cooling   <= 1'b0;
      valve     <= 4'b0000;
      zone_sel  <= 2'd0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          heating  <= 1'b0;
          cooling  <= 1'b0;
          valve    <= 4'b0000;
          busy     <= 1'b0;
          lock_cnt <= 8'd0;
          if (grant_valid) begin
            state     <= ST_SERVE;
            zone_sel  <= grant_idx;
            mode_heat <= heat_dem[grant_idx];
            heating   <= heat_dem[grant_idx];
            cooling   <= !heat_dem[grant_idx];
            valve     <= 4'b0001 << grant_idx;
            busy      <= 1'b1;
            dwell_cnt <= 8'd1;
          end
        end
        ST_SERVE: begin
          if (serve_done) begin
            state     <= ST_LOCKOUT;
            heating   <= 1'b0;
            cooling   <= 1'b0;
            valve     <= 4'b0000;
            rr_ptr    <= zone_sel + 2'd1;
            lock_cnt  <= 8'd1;
            dwell_cnt <= 8'd0;
          end else if (dwell_cnt != CNT_SAT) begin
            dwell_cnt <= dwell_cnt + 8'd1;
          end
        end
        ST_LOCKOUT: begin
          heating <= 1'b0;
          cooling <= 1'b0;
          valve   <= 4'b0000;
          if (lock_cnt >= LOCK_MAX) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            lock_cnt <= 8'd0;
          end else if (lock_cnt != CNT_SAT) begin
            lock_cnt <= lock_cnt + 8'd1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          heating <= 1'b0;
          cooling <= 1'b0;
          valve   <= 4'b0000;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ac_zone_scheduler.sv
// tb_ac_zone_scheduler: directed checks of ac_zone_scheduler with default
// parameters (MAX_DWELL = 16, LOCKOUT = 4). The expected grant order follows
// the AC_SCHED_ZONE0_PRIORITY_EN build option.
module tb_ac_zone_scheduler;

  logic        clk;
  logic        rst;
  logic [19:0] temperature;
  logic [3:0]  zone_en;
  logic        heating;
  logic        cooling;
  logic [3:0]  valve;
  logic [1:0]  zone_sel;
  logic        busy;

  int total;
  int bad;

`ifdef AC_SCHED_ZONE0_PRIORITY_EN
  localparam logic [1:0] SECOND_SEL   = 2'd0;
  localparam logic [3:0] SECOND_VALVE = 4'b0001;
  localparam logic [1:0] ALT_SEL      = 2'd0;
  localparam logic [3:0] ALT_VALVE    = 4'b0001;
`else
  localparam logic [1:0] SECOND_SEL   = 2'd1;
  localparam logic [3:0] SECOND_VALVE = 4'b0010;
  localparam logic [1:0] ALT_SEL      = 2'd3;
  localparam logic [3:0] ALT_VALVE    = 4'b1000;
`endif

  ac_zone_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .temperature (temperature),
    .zone_en     (zone_en),
    .heating     (heating),
    .cooling     (cooling),
    .valve       (valve),
    .zone_sel    (zone_sel),
    .busy        (busy)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive all four zone temperatures and the enables.
  task automatic applyStimulus(input logic [4:0] t0, input logic [4:0] t1,
                               input logic [4:0] t2, input logic [4:0] t3,
                               input logic [3:0] en);
    temperature = {t3, t2, t1, t0};
    zone_en     = en;
  endtask

  // Compare every output against the expected values.
  task automatic checkOutput(input string tag, input logic eh, input logic ec,
                             input logic [3:0] ev, input logic [1:0] es, input logic eb);
    logic [8:0] obs;
    logic [8:0] exp;
    obs = {heating, cooling, valve, zone_sel, busy};
    exp = {eh, ec, ev, es, eb};
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed{h,c,valve,sel,busy}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Advance n cycles and check the outputs after each one.
  task automatic tickCheck(input int n, input string tag, input logic eh, input logic ec,
                           input logic [3:0] ev, input logic [1:0] es, input logic eb);
    for (int i = 0; i < n; i++) begin
      tick();
      checkOutput(tag, eh, ec, ev, es, eb);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(5'd20, 5'd20, 5'd20, 5'd20, 4'hF);
    tick();
    tickCheck(1, "reset_state", 0, 0, 4'b0000, 2'd0, 0);
    rst = 1'b0;

    $display("[TB] all zones at setpoint");
    tickCheck(8, "idle_all20", 0, 0, 4'b0000, 2'd0, 0);

    $display("[TB] zone 2 heat then satisfied");
    applyStimulus(5'd20, 5'd20, 5'd15, 5'd20, 4'hF);
    tickCheck(1, "z2_heat_grant", 1, 0, 4'b0100, 2'd2, 1);
    tickCheck(2, "z2_heat_hold", 1, 0, 4'b0100, 2'd2, 1);
    applyStimulus(5'd20, 5'd20, 5'd20, 5'd20, 4'hF);
    tickCheck(4, "z2_lockout", 0, 0, 4'b0000, 2'd2, 1);
    tickCheck(1, "z2_back_idle", 0, 0, 4'b0000, 2'd2, 0);

    $display("[TB] zones 0 and 1 cooling, never satisfied");
    applyStimulus(5'd25, 5'd25, 5'd20, 5'd20, 4'hF);
    tickCheck(16, "z0_cool_dwell", 0, 1, 4'b0001, 2'd0, 1);
    tickCheck(4, "z0_cool_lockout", 0, 0, 4'b0000, 2'd0, 1);
    tickCheck(1, "z0_cool_idle", 0, 0, 4'b0000, 2'd0, 0);
    tickCheck(16, "second_cool_dwell", 0, 1, SECOND_VALVE, SECOND_SEL, 1);
    tickCheck(4, "second_cool_lockout", 0, 0, 4'b0000, SECOND_SEL, 1);
    tickCheck(1, "second_cool_idle", 0, 0, 4'b0000, SECOND_SEL, 0);
    tickCheck(1, "third_cool_grant", 0, 1, 4'b0001, 2'd0, 1);

    $display("[TB] reset during serve");
    rst = 1'b1;
    applyStimulus(5'd20, 5'd20, 5'd20, 5'd20, 4'hF);
    tickCheck(1, "rst_mid_serve", 0, 0, 4'b0000, 2'd0, 0);
    rst = 1'b0;
    tickCheck(2, "post_rst_idle", 0, 0, 4'b0000, 2'd0, 0);

    $display("[TB] zone 3 dwell expiry and pointer wrap");
    applyStimulus(5'd20, 5'd20, 5'd20, 5'd10, 4'hF);
    tickCheck(1, "z3_grant", 1, 0, 4'b1000, 2'd3, 1);
    applyStimulus(5'd10, 5'd20, 5'd20, 5'd10, 4'hF);
    tickCheck(15, "z3_dwell", 1, 0, 4'b1000, 2'd3, 1);
    tickCheck(4, "z3_lockout", 0, 0, 4'b0000, 2'd3, 1);
    tickCheck(1, "z3_idle", 0, 0, 4'b0000, 2'd3, 0);
    tickCheck(1, "wrap_z0_grant", 1, 0, 4'b0001, 2'd0, 1);

    $display("[TB] zones 0 and 3 both heating");
    tickCheck(15, "z0_dwell", 1, 0, 4'b0001, 2'd0, 1);
    tickCheck(4, "z0_lockout", 0, 0, 4'b0000, 2'd0, 1);
    tickCheck(1, "z0_idle", 0, 0, 4'b0000, 2'd0, 0);
    tickCheck(1, "after_z0_grant", 1, 0, ALT_VALVE, ALT_SEL, 1);

    $display("[TB] enable drop and reset in lockout");
    rst = 1'b1;
    applyStimulus(5'd20, 5'd20, 5'd20, 5'd20, 4'hF);
    tickCheck(1, "rst_clear", 0, 0, 4'b0000, 2'd0, 0);
    rst = 1'b0;
    applyStimulus(5'd20, 5'd10, 5'd20, 5'd20, 4'hF);
    tickCheck(1, "z1_grant", 1, 0, 4'b0010, 2'd1, 1);
    tickCheck(1, "z1_hold", 1, 0, 4'b0010, 2'd1, 1);
    applyStimulus(5'd20, 5'd10, 5'd20, 5'd20, 4'b1101);
    tickCheck(1, "z1_en_drop_lockout", 0, 0, 4'b0000, 2'd1, 1);
    tickCheck(1, "z1_lockout2", 0, 0, 4'b0000, 2'd1, 1);
    rst = 1'b1;
    tickCheck(1, "rst_mid_lockout", 0, 0, 4'b0000, 2'd0, 0);
    rst = 1'b0;
    applyStimulus(5'd20, 5'd10, 5'd20, 5'd25, 4'hF);
    tickCheck(1, "rr_resume_z1", 1, 0, 4'b0010, 2'd1, 1);

    $display("[TB] demand thresholds and disabled zone");
    rst = 1'b1;
    applyStimulus(5'd20, 5'd20, 5'd20, 5'd20, 4'hF);
    tickCheck(1, "rst_bounds", 0, 0, 4'b0000, 2'd0, 0);
    rst = 1'b0;
    applyStimulus(5'd18, 5'd22, 5'd18, 5'd5, 4'b0111);
    tickCheck(3, "no_demand_bounds", 0, 0, 4'b0000, 2'd0, 0);
    applyStimulus(5'd17, 5'd22, 5'd18, 5'd5, 4'b0111);
    tickCheck(1, "heat_17_grant", 1, 0, 4'b0001, 2'd0, 1);
    applyStimulus(5'd19, 5'd22, 5'd18, 5'd5, 4'b0111);
    tickCheck(1, "heat_19_hold", 1, 0, 4'b0001, 2'd0, 1);
    applyStimulus(5'd20, 5'd22, 5'd18, 5'd5, 4'b0111);
    tickCheck(1, "heat_20_lockout", 0, 0, 4'b0000, 2'd0, 1);
    tickCheck(3, "heat_lockout_rest", 0, 0, 4'b0000, 2'd0, 1);
    tickCheck(1, "heat_idle", 0, 0, 4'b0000, 2'd0, 0);
    applyStimulus(5'd20, 5'd22, 5'd23, 5'd5, 4'b0111);
    tickCheck(1, "cool_23_grant", 0, 1, 4'b0100, 2'd2, 1);
    applyStimulus(5'd20, 5'd22, 5'd21, 5'd5, 4'b0111);
    tickCheck(1, "cool_21_hold", 0, 1, 4'b0100, 2'd2, 1);
    applyStimulus(5'd20, 5'd22, 5'd20, 5'd5, 4'b0111);
    tickCheck(1, "cool_20_lockout", 0, 0, 4'b0000, 2'd2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
